// File: rtl/vga_framebuffer_reader.sv
// Frame-buffer reader for the VGA pixel path: address generation, RAM read pipeline,
// direct / palette / colour-bar colour selection with a fixed p_MEM_LATENCY+2 latency.
module vga_framebuffer_reader #(
  parameter int p_H_VISIBLE_AREA = 640,
  parameter int p_V_VISIBLE_AREA = 480,
  parameter int p_COLOR_BITS     = 8,
  parameter int p_SCALE_SHIFT    = 0,
  parameter int p_MEM_LATENCY    = 1,
  parameter int p_ADDR_WIDTH     = $clog2((p_H_VISIBLE_AREA >> p_SCALE_SHIFT) *
                                          (p_V_VISIBLE_AREA >> p_SCALE_SHIFT))
) (
  input  logic                                  i_CLK,
  input  logic                                  i_RST_N,
  input  logic                                  i_DRAW_ENABLE,
  input  logic [$clog2(p_H_VISIBLE_AREA)-1:0]   i_SCANLINE_X,
  input  logic [$clog2(p_V_VISIBLE_AREA)-1:0]   i_SCANLINE_Y,
  input  logic [1:0]                            i_MODE,
  input  logic                                  i_PAL_WE,
  input  logic [7:0]                            i_PAL_ADDR,
  input  logic [3*p_COLOR_BITS-1:0]             i_PAL_DATA,
  output logic [p_ADDR_WIDTH-1:0]               o_MEM_ADDR,
  output logic                                  o_MEM_RD,
  input  logic [3*p_COLOR_BITS-1:0]             i_MEM_DATA,
  output logic [p_COLOR_BITS-1:0]               o_VGA_RED,
  output logic [p_COLOR_BITS-1:0]               o_VGA_GREEN,
  output logic [p_COLOR_BITS-1:0]               o_VGA_BLUE,
  output logic                                  o_DRAW_ENABLE
);

  localparam int c_DW         = 3 * p_COLOR_BITS;
  localparam int c_LINE_WORDS = p_H_VISIBLE_AREA >> p_SCALE_SHIFT;
  localparam int c_BAR_WIDTH  = p_H_VISIBLE_AREA / 8;

  localparam logic [1:0] c_MODE_DIRECT  = 2'd0;
  localparam logic [1:0] c_MODE_INDEXED = 2'd1;
  localparam logic [1:0] c_MODE_PATTERN = 2'd2;

  typedef struct packed {
    logic       en;
    logic       blank;
    logic [1:0] mode;
    logic [2:0] bar;
  } meta_t;

  logic            frame_start;
  logic            out_of_range;
  logic [1:0]      req_mode;
  logic [1:0]      active_mode;
  logic [1:0]      pixel_mode;
  logic [2:0]      bar_a;
  meta_t           meta_pipe [p_MEM_LATENCY+1];
  meta_t           meta_b;
  logic [c_DW-1:0] data_b;
  logic [c_DW-1:0] palette [256];
  logic [c_DW-1:0] rgb_next;

  // The frame-start pixel already uses the requested mode, so bypass the register.
  always_comb begin
    frame_start  = i_DRAW_ENABLE && (i_SCANLINE_X == '0) && (i_SCANLINE_Y == '0);
    req_mode     = (i_MODE == 2'd3) ? c_MODE_DIRECT : i_MODE;
    pixel_mode   = frame_start ? req_mode : active_mode;
    out_of_range = (32'(i_SCANLINE_X) >= 32'(p_H_VISIBLE_AREA)) ||
                   (32'(i_SCANLINE_Y) >= 32'(p_V_VISIBLE_AREA));
    bar_a        = 3'(32'(i_SCANLINE_X) / 32'(c_BAR_WIDTH));
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_MEM_ADDR  <= '0;
      o_MEM_RD    <= 1'b0;
      active_mode <= c_MODE_DIRECT;
      for (int i = 0; i <= p_MEM_LATENCY; i++) meta_pipe[i] <= '0;
    end else begin
      if (frame_start) active_mode <= req_mode;
      o_MEM_ADDR <= out_of_range ? '0 :
                    p_ADDR_WIDTH'((32'(i_SCANLINE_Y) >> p_SCALE_SHIFT) * 32'(c_LINE_WORDS) +
                                  (32'(i_SCANLINE_X) >> p_SCALE_SHIFT));
      o_MEM_RD     <= i_DRAW_ENABLE && (pixel_mode != c_MODE_PATTERN);
      meta_pipe[0] <= '{en: i_DRAW_ENABLE, blank: out_of_range, mode: pixel_mode, bar: bar_a};
      for (int i = 1; i <= p_MEM_LATENCY; i++) meta_pipe[i] <= meta_pipe[i-1];
    end
  end

  // RAM word lands alongside the pixel's metadata at the end of the delay line.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) data_b <= '0;
    else          data_b <= i_MEM_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (i_PAL_WE) palette[i_PAL_ADDR] <= i_PAL_DATA;
  end

  assign meta_b = meta_pipe[p_MEM_LATENCY];

  // Bar order white..black: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
  always_comb begin
    rgb_next = '0;
    if (meta_b.en && !meta_b.blank) begin
      case (meta_b.mode)
        c_MODE_INDEXED: rgb_next = palette[data_b[7:0]];
        c_MODE_PATTERN: rgb_next = {{p_COLOR_BITS{~meta_b.bar[1]}},
                                    {p_COLOR_BITS{~meta_b.bar[2]}},
                                    {p_COLOR_BITS{~meta_b.bar[0]}}};
        default:        rgb_next = data_b;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_VGA_RED     <= '0;
      o_VGA_GREEN   <= '0;
      o_VGA_BLUE    <= '0;
      o_DRAW_ENABLE <= 1'b0;
    end else begin
      o_VGA_RED     <= rgb_next[c_DW-1 -: p_COLOR_BITS];
      o_VGA_GREEN   <= rgb_next[2*p_COLOR_BITS-1 -: p_COLOR_BITS];
      o_VGA_BLUE    <= rgb_next[p_COLOR_BITS-1:0];
      o_DRAW_ENABLE <= meta_b.en;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader: a 640x480 latency-2 instance checked every cycle
// against a pixel-level model, plus a scale-2 latency-1 instance driven from a table.
module tb_vga_framebuffer_reader;
  localparam int H = 640, V = 480, LAT = 2, L = LAT + 2, L2 = 3;
  localparam int AW = 19, AW2 = 17;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          de_in, pal_we;
  logic [9:0]    x_in;
  logic [8:0]    y_in;
  logic [1:0]    mode_in;
  logic [7:0]    pal_addr;
  logic [23:0]   pal_data, mem_data, mem_q;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, de_out;
  logic [7:0]    red, green, blue;

  logic           de2_in, mem_rd2, de2_out;
  logic [9:0]     x2_in;
  logic [8:0]     y2_in;
  logic [AW2-1:0] mem_addr2;
  logic [23:0]    mem_data2;
  logic [7:0]     red2, green2, blue2;

  bit ram_sel;

  vga_framebuffer_reader #(.p_MEM_LATENCY(LAT)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_DRAW_ENABLE(de_in), .i_SCANLINE_X(x_in),
    .i_SCANLINE_Y(y_in), .i_MODE(mode_in), .i_PAL_WE(pal_we), .i_PAL_ADDR(pal_addr),
    .i_PAL_DATA(pal_data), .o_MEM_ADDR(mem_addr), .o_MEM_RD(mem_rd), .i_MEM_DATA(mem_data),
    .o_VGA_RED(red), .o_VGA_GREEN(green), .o_VGA_BLUE(blue), .o_DRAW_ENABLE(de_out));

  vga_framebuffer_reader #(.p_SCALE_SHIFT(1)) dut_s (
    .i_CLK(clk), .i_RST_N(rst_n), .i_DRAW_ENABLE(de2_in), .i_SCANLINE_X(x2_in),
    .i_SCANLINE_Y(y2_in), .i_MODE(2'b00), .i_PAL_WE(1'b0), .i_PAL_ADDR(8'h00),
    .i_PAL_DATA(24'h0), .o_MEM_ADDR(mem_addr2), .o_MEM_RD(mem_rd2), .i_MEM_DATA(mem_data2),
    .o_VGA_RED(red2), .o_VGA_GREEN(green2), .o_VGA_BLUE(blue2), .o_DRAW_ENABLE(de2_out));

  // Frame-buffer contents: either {addr,55,AA} or {55,AA,addr} so indexed mode sees addr as the index.
  function automatic logic [23:0] ram_word(input int unsigned a, input bit rs);
    logic [7:0] lo;
    lo = a[7:0];
    return rs ? {8'h55, 8'hAA, lo} : {lo, 8'h55, 8'hAA};
  endfunction

  // Latency-2 RAM: one register after the DUT's address register; latency-1 RAM is combinational.
  always @(posedge clk) if (mem_rd) mem_q <= ram_word(32'(mem_addr), ram_sel);
  assign mem_data  = mem_q;
  assign mem_data2 = ram_word(32'(mem_addr2), 1'b0);

  typedef struct { int en; int x; int y; int mode; int rs; } ent_t;
  ent_t        q[$];
  logic [23:0] pal_m [256];
  logic [23:0] bar_rgb [8];
  int          act_m;
  int          pend_we;
  logic [7:0]  pend_a;
  logic [23:0] pend_d;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [24:0] model_pix(input ent_t e);
    logic [23:0] w;
    if (e.en == 0) return '0;
    if (e.x >= H || e.y >= V) return {1'b1, 24'h0};
    if (e.mode == 2) return {1'b1, bar_rgb[e.x / (H / 8)]};
    w = ram_word(e.y * H + e.x, e.rs != 0);
    if (e.mode == 1) return {1'b1, pal_m[w[7:0]]};
    return {1'b1, w};
  endfunction

  task automatic apply(input int x, y, en, m, we, pa, pd);
    ent_t e;
    x_in = 10'(x); y_in = 9'(y); de_in = 1'(en); mode_in = 2'(m);
    pal_we = 1'(we); pal_addr = 8'(pa); pal_data = 24'(pd);
    if (en != 0 && x == 0 && y == 0) act_m = (m == 3) ? 0 : m;
    e.en = en; e.x = x; e.y = y; e.mode = act_m; e.rs = int'(ram_sel);
    q.push_back(e);
    pend_we = we; pend_a = 8'(pa); pend_d = 24'(pd);
  endtask

  // One clock: check the pixel that entered L cycles ago and the address of last cycle's pixel.
  task automatic step(input int x, y, en, m, we, pa, pd);
    ent_t o, last;
    logic [24:0] e;
    @(posedge clk); #1;
    o = q.pop_front();
    last = q[$];
    e = model_pix(o);
    chk("pixel", 64'({de_out, red, green, blue}), 64'(e));
    chk("mem_rd", 64'(mem_rd), 64'(last.en != 0 && last.mode != 2));
    if (last.en != 0)
      chk("mem_addr", 64'(mem_addr), (last.x >= H || last.y >= V) ? 64'd0 : 64'(last.y * H + last.x));
    if (pend_we != 0) pal_m[pend_a] = pend_d;
    apply(x, y, en, m, we, pa, pd);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reinit();
    de_in = 0; x_in = 0; y_in = 0; mode_in = 0; pal_we = 0; pal_addr = 0; pal_data = 0;
    q.delete();
    repeat (L) q.push_back('{en: 0, x: 0, y: 0, mode: 0, rs: 0});
    act_m = 0; pend_we = 0;
  endtask

  typedef struct { int x; logic [23:0] rgb; } tp_t;
  typedef struct { int x; int y; int en; int oor; int addr; } s2_t;
  tp_t tp_tab [7];
  s2_t s2_tab [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tp_tab = '{'{0, 24'hFFFFFF}, '{79, 24'hFFFFFF}, '{80, 24'hFFFF00}, '{160, 24'h00FFFF},
               '{400, 24'hFF0000}, '{520, 24'h0000FF}, '{639, 24'h000000}};
    s2_tab = '{'{0, 0, 1, 0, 0}, '{1, 0, 1, 0, 0}, '{0, 1, 1, 0, 0}, '{1, 1, 1, 0, 0},
               '{2, 2, 1, 0, 321}, '{639, 479, 1, 0, 76799}, '{3, 200, 1, 0, 32001},
               '{700, 10, 1, 1, 0}, '{5, 5, 0, 0, 0}};
    bar_rgb = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    ram_sel = 0; mem_q = '0;
    de2_in = 0; x2_in = 0; y2_in = 0;
    reinit();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 64'({de_out, red, green, blue, mem_rd}), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_out_s", 64'({de2_out, red2, green2, blue2, mem_rd2, mem_addr2}), 64'd0);
    reinit();
    rst_n = 1;

    for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 1, i, int'($urandom_range(0, 24'hFFFFFF)));

    // Direct mode: (5,1) -> address 645 next cycle, {85,55,AA} L cycles later.
    step(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    step(5, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("direct_addr", 64'({mem_rd, mem_addr}), 64'({1'b1, 19'd645}));
    idle(L - 1);
    chk("direct_pix", 64'({de_out, red, green, blue}), 64'({1'b1, 24'h8555AA}));

    // Indexed mode and palette write/read collision.
    idle(L + 1);
    ram_sel = 1;
    step(0, 0, 0, 0, 1, 'h12, 'h102030);
    step(0, 0, 1, 1, 0, 0, 0);
    step('h12, 0, 1, 1, 0, 0, 0);
    step('h12, 0, 1, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 'h12, 'hFFFFFF);
    idle(1);
    chk("pal_old", 64'({de_out, red, green, blue}), 64'({1'b1, 24'h102030}));
    idle(1);
    chk("pal_new", 64'({de_out, red, green, blue}), 64'({1'b1, 24'hFFFFFF}));

    // Colour bars.
    idle(L + 1);
    ram_sel = 0;
    step(0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(tp_tab[i].x, 5, 1, 2, 0, 0, 0);
      idle(1);
      chk("tp_rd", 64'(mem_rd), 64'd0);
      idle(L - 1);
      chk("tp_pix", 64'({de_out, red, green, blue}), 64'({1'b1, tp_tab[i].rgb}));
    end

    // Mode request mid-frame is held off until the next frame start.
    step(0, 0, 1, 0, 0, 0, 0);
    for (int x = 298; x < 300; x++) step(x, 10, 1, 0, 0, 0, 0);
    for (int x = 300; x <= 300 + L; x++) step(x, 10, 1, 2, 0, 0, 0);
    chk("mode_hold", 64'({de_out, red, green, blue}), 64'({1'b1, 24'h2C55AA}));
    step(639, 479, 1, 2, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 1, 2, 0, 0, 0);
    idle(L - 1);
    chk("mode_switch", 64'({de_out, red, green, blue}), 64'({1'b1, 24'hFFFFFF}));

    // Randomised traffic against the model.
    for (int rs = 0; rs < 2; rs++) begin
      idle(L + 1);
      ram_sel = rs[0];
      for (int n = 0; n < 300; n++) begin
        int x, y, en;
        if ($urandom_range(0, 19) == 0) begin
          x = 0; y = 0; en = 1;
        end else begin
          x = int'($urandom_range(0, 700));
          y = int'($urandom_range(0, 511));
          en = ($urandom_range(0, 3) != 0) ? 1 : 0;
        end
        step(x, y, en, int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 1 : 0,
             int'($urandom_range(0, 255)), int'($urandom_range(0, 24'hFFFFFF)));
      end
    end

    // Reset mid-line.
    idle(L + 1);
    ram_sel = 0;
    step(0, 0, 1, 2, 0, 0, 0);
    step(10, 3, 1, 2, 0, 0, 0);
    step(11, 3, 1, 2, 0, 0, 0);
    idle(L - 1);
    rst_n = 0;
    #1;
    chk("rst_async", 64'({de_out, red, green, blue, mem_rd, mem_addr}), 64'd0);
    @(posedge clk); #1;
    reinit();
    rst_n = 1;
    step(7, 3, 1, 2, 0, 0, 0);
    idle(L - 1);
    chk("rst_no_early", 64'(de_out), 64'd0);
    idle(1);
    chk("rst_first_pix", 64'({de_out, red, green, blue}), 64'({1'b1, 24'h8755AA}));

    // Scale-2 instance: address folding, clamping and blanking.
    for (int i = 0; i < 9; i++) begin
      logic [7:0]  lo;
      logic [24:0] exp_pix;
      lo = 8'(s2_tab[i].addr);
      if (s2_tab[i].en == 0)      exp_pix = '0;
      else if (s2_tab[i].oor != 0) exp_pix = {1'b1, 24'h0};
      else                         exp_pix = {1'b1, lo, 8'h55, 8'hAA};
      idle(1);
      x2_in = 10'(s2_tab[i].x); y2_in = 9'(s2_tab[i].y); de2_in = 1'(s2_tab[i].en);
      idle(1);
      chk("s2_rd", 64'(mem_rd2), 64'(s2_tab[i].en));
      if (s2_tab[i].en != 0) chk("s2_addr", 64'(mem_addr2), 64'(s2_tab[i].addr));
      de2_in = 0;
      idle(L2 - 1);
      chk("s2_pix", 64'({de2_out, red2, green2, blue2}), 64'(exp_pix));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
